// File: rtl/apb_ic_pkg.sv
// apb_ic_pkg
// Shared definitions for the APB slave interconnect, request FIFO and
// round-robin arbiter. The arbiter imports apb_req_t from here, so the
// request layout stays identical on both sides of the FIFO.
package apb_ic_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  // One buffered APB request.
  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/apb_req_fifo_mem.sv
// apb_req_fifo_mem
// Simple dual-port storage for the request FIFO: synchronous write,
// asynchronous read. Contents are deliberately not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - entry to store
//   raddr - read index
//   rdata - entry at raddr (combinational)
module apb_req_fifo_mem
  import apb_ic_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = apb_req_t
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_req_fifo.sv
// apb_req_fifo
// Request FIFO between the APB slave interconnect and the round-robin
// arbiter. Buffers {write, addr, wdata}, acknowledges every accepted push
// with a one-cycle registered pulse and presents the oldest entry in
// show-ahead form.
//
// Handshake: the push side is push_in qualified by !full_o, except that a
// push at full is still accepted when pop_in frees a slot in the same cycle;
// acceptance is reported one cycle later on fifo_data_in_ack. The pop side is
// valid/ready: pop_valid_o is valid, pop_in is ready, and an entry leaves on
// a rising edge where both are high. pop_in while empty is an underflow.
//
// Ports:
//   fifo_clk, fifo_reset       - clock, async active-high reset
//   push_in, fifo_write,
//   push_addr_in, push_wdata_in- push request and its payload
//   fifo_data_in_ack           - one-cycle pulse per accepted push
//   full_o, empty_o, count_o   - occupancy status (registered state only)
//   pop_in, pop_valid_o,
//   pop_write_o, pop_addr_o,
//   pop_wdata_o                - head entry and consume strobe
//   ovf_o, udf_o, err_clr_in   - sticky overflow/underflow and their clear
module apb_req_fifo
  import apb_ic_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = APB_AW,
  parameter int DW    = APB_DW
) (
  input  logic                   fifo_clk,
  input  logic                   fifo_reset,
  input  logic                   push_in,
  input  logic                   fifo_write,
  input  logic [AW-1:0]          push_addr_in,
  input  logic [DW-1:0]          push_wdata_in,
  output logic                   fifo_data_in_ack,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  input  logic                   pop_in,
  output logic                   pop_valid_o,
  output logic                   pop_write_o,
  output logic [AW-1:0]          pop_addr_o,
  output logic [DW-1:0]          pop_wdata_o,
  output logic                   ovf_o,
  output logic                   udf_o,
  input  logic                   err_clr_in
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

  // Same layout as apb_req_t, sized by this instance's AW/DW.
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          ack;
  logic          ovf;
  logic          udf;
  logic          push_acc;
  logic          pop_acc;
  req_t          wr_entry;
  req_t          head;

  // Full: same slot index, opposite lap. Empty: identical pointers.
  assign full_o  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty_o = (wr_ptr == rd_ptr);

  // A pop at full frees the slot being written, so the push may proceed.
  assign push_acc = push_in && (!full_o || pop_in);
  assign pop_acc  = pop_in && !empty_o;

  assign wr_entry.write = fifo_write;
  assign wr_entry.addr  = push_addr_in;
  assign wr_entry.wdata = push_wdata_in;

  apb_req_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_mem (
    .clk   (fifo_clk),
    .we    (push_acc),
    .waddr (wr_ptr[IW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[IW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      ack <= push_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      if (push_acc && !pop_acc) begin
        count <= count + ONE;
      end else if (pop_acc && !push_acc) begin
        count <= count - ONE;
      end
      // Setting wins over a same-cycle clear.
      if (push_in && !push_acc) begin
        ovf <= 1'b1;
      end else if (err_clr_in) begin
        ovf <= 1'b0;
      end
      if (pop_in && empty_o) begin
        udf <= 1'b1;
      end else if (err_clr_in) begin
        udf <= 1'b0;
      end
    end
  end

  assign fifo_data_in_ack = ack;
  assign count_o          = count;
  assign ovf_o            = ovf;
  assign udf_o            = udf;
  assign pop_valid_o      = !empty_o;
  assign pop_write_o      = head.write;
  assign pop_addr_o       = head.addr;
  assign pop_wdata_o      = head.wdata;

endmodule

// File: doc/apb_req_fifo.md
# apb_req_fifo

Synchronous request FIFO between `apb_slave_interconnect` and the round-robin arbiter. It buffers each APB write or read request that the slave pushes: write flag, 32-bit address and 32-bit write data. It acknowledges each accepted push with a one-cycle pulse and exposes the oldest entry to the arbiter in show-ahead (first-word fall-through) form. It also reports full/empty, an occupancy count and sticky overflow/underflow errors.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, ≥ 2.
- `AW`, default 32: address width.
- `DW`, default 32: write-data width.

Ports:
- `fifo_clk`  in  1  sole clock; all logic on its rising edge.
- `fifo_reset`  in  1  asynchronous, active-high reset.
- `push_in`  in  1  push request from slave.
- `fifo_write`  in  1  request type: 1 = APB write, 0 = read.
- `push_addr_in`  in  AW  request address.
- `push_wdata_in`  in  DW  request write data; stored for reads too.
- `fifo_data_in_ack`  out  1  one-cycle pulse, one per accepted push.
- `full_o`  out  1  count == DEPTH.
- `empty_o`  out  1  count == 0.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.
- `pop_in`  in  1  arbiter consumes head entry.
- `pop_valid_o`  out  1  head entry valid; equals !empty_o.
- `pop_write_o`  out  1  head write flag.
- `pop_addr_o`  out  AW  head address.
- `pop_wdata_o`  out  DW  head write data.
- `ovf_o`  out  1  sticky flag: push attempted while full and not accepted.
- `udf_o`  out  1  sticky flag: pop attempted while empty.
- `err_clr_in`  in  1  clears `ovf_o` and `udf_o`.

## Operation
- Storage: DEPTH × (1+AW+DW) array. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. Full when the pointers are equal except for the MSB. Empty when the pointers are fully equal.
- Push accept: `push_in && (!full_o || pop_in)`. Pop accept: `pop_in && !empty_o`.
- Full with simultaneous push and pop: both are accepted; count is unchanged and `full_o` stays 1.
- Empty with simultaneous push and pop: the pop is rejected (`udf_o` sets) and the push is accepted; count becomes 1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither. Pointers increment modulo 2·DEPTH.
- Rejected push leaves the contents unchanged, produces no ack and sets `ovf_o`.
- Head outputs are driven from the read pointer. When empty, head outputs hold the last array contents; consumers qualify them with `pop_valid_o`.
- Sticky errors: set has priority over `err_clr_in` in the same cycle.
- No FSM beyond pointer/count state. The ack is a registered pulse: one pulse per accepted push, and back-to-back pushes give consecutive ack cycles.

## Timing
- Reset (async assert; deassertion sampled at the next `fifo_clk` edge):
  - pointers = 0, count_o = 0, empty_o = 1, full_o = 0, pop_valid_o = 0, fifo_data_in_ack = 0, ovf_o = 0, udf_o = 0.
  - Array contents are not reset.
- Push at edge N → `fifo_data_in_ack` high during cycle N+1 only. If the FIFO was empty, `pop_valid_o` and head data are valid in cycle N+1.
- Pop at edge N → the next entry appears on the head outputs in cycle N+1, with no bubble.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-transfer discards all entries immediately and forces the ack low, with no completion.
- `full_o`, `empty_o`, `count_o` are registered or derived from registered pointers only; no combinational path from `push_in` or `pop_in` to them.
- Combinational path `pop_in` → `push` accept at full is permitted; no other input-to-output combinational paths.

## Structure
- Shared package `apb_ic_pkg`:
  - `apb_req_t` struct {write, addr[AW], wdata[DW]}.
  - constants `APB_AW = 32`, `APB_DW = 32`.
  - The arbiter imports the same struct.
- Sub-module `apb_req_fifo_mem`: simple dual-port array, synchronous write and asynchronous read, parameterised on DEPTH and `apb_req_t`.
- Top holds the pointers, count, flags and ack register.

## Test plan
- Reset, then push {write=1, addr=0x10, wdata=0xA5A5A5A5} → ack pulses one cycle; next cycle `pop_valid_o` = 1, head = {1, 0x10, 0xA5A5A5A5}, count_o = 1.
- Push 8 entries with addr 0x00..0x1C → full_o = 1, count_o = 8; a 9th push gives no ack and sets ovf_o. Popping 8 returns addr 0x00..0x1C in order, then empty_o = 1.
- At full, push addr 0x40 and pop in the same cycle → count stays 8, ack pulses, and 0x40 pops last.
- Empty, pop_in = 1 → udf_o = 1 and count stays 0; err_clr_in clears it. Same-cycle push+pop on empty → count = 1, udf_o = 1.
- Continuous push/pop for 20 cycles across pointer wrap → count constant, data order preserved, no flags set.
- Assert fifo_reset with 3 entries stored and a push in flight → all outputs return to reset values in the same cycle and no ack is issued.
